// File: rtl/nios2_debug_pkg.sv
// nios2_debug_pkg
// Shared definitions for the Nios II JTAG debug command bridge:
//   - default JTAG data-register and instruction widths
//   - instruction encodings carried in each command
//   - the command record {ir, data} at default widths
package nios2_debug_pkg;

  localparam int SR_W_DEF = 38;
  localparam int IR_W_DEF = 2;

  typedef enum logic [IR_W_DEF-1:0] {
    IR_OCIMEM    = 2'd0,
    IR_TRACEMEM  = 2'd1,
    IR_BREAK     = 2'd2,
    IR_TRACECTRL = 2'd3
  } ir_e;

  typedef struct packed {
    logic [IR_W_DEF-1:0] ir;
    logic [SR_W_DEF-1:0] data;
  } cmd_t;

endpackage

// File: rtl/nios2_sync_edge.sv
// nios2_sync_edge
// Brings one asynchronous level into the clk domain and produces a
// registered one-cycle pulse on its rising edge.
// Ports:
//   clk      system clock
//   reset    asynchronous active-high reset
//   async_in level from another clock domain
//   rise     one-cycle pulse, high the cycle after a rising edge is seen
module nios2_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic rise
);

  logic [STAGES-1:0] sync_q;
  logic              edge_q;

  // The edge flop resets to 0, so a level already high at reset release
  // still yields exactly one pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
      edge_q <= 1'b0;
      rise   <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], async_in};
      edge_q <= sync_q[STAGES-1];
      rise   <= sync_q[STAGES-1] & ~edge_q;
    end
  end

endmodule

// File: rtl/nios2_debug_cmd_bridge.sv
// nios2_debug_cmd_bridge
// Moves JTAG debug commands (instruction + data register) into the system
// clock domain through a small FIFO and replays them as one-hot action
// strobes.
// Ports:
//   clk, reset          system clock, asynchronous active-high reset
//   vs_udr, vs_uir      JTAG update-DR / update-IR levels (asynchronous)
//   ir_in, sr           JTAG instruction and data register
//   cmd_ready           consumer accepts the head command
//   ovf_clr             clears the sticky overflow flag
//   cmd_valid, cmd_ir   queue non-empty, head instruction
//   jdo, take_action    popped data, one-hot strobe of popped instruction
//   ir_update, ir_cur   update-IR pulse and captured instruction
//   overflow, level     sticky drop flag, queue occupancy
module nios2_debug_cmd_bridge
  import nios2_debug_pkg::*;
#(
  parameter int SR_W        = SR_W_DEF,
  parameter int IR_W        = IR_W_DEF,
  parameter int SYNC_STAGES = 2,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         vs_udr,
  input  logic                         vs_uir,
  input  logic [IR_W-1:0]              ir_in,
  input  logic [SR_W-1:0]              sr,
  input  logic                         cmd_ready,
  input  logic                         ovf_clr,
  output logic                         cmd_valid,
  output logic [IR_W-1:0]              cmd_ir,
  output logic [SR_W-1:0]              jdo,
  output logic [2**IR_W-1:0]           take_action,
  output logic                         ir_update,
  output logic [IR_W-1:0]              ir_cur,
  output logic                         overflow,
  output logic [$clog2(FIFO_DEPTH):0]  level
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int NA_W  = 2**IR_W;

  logic udr_rise;
  logic uir_rise;

  nios2_sync_edge #(.STAGES(SYNC_STAGES)) u_udr_sync (
    .clk      (clk),
    .reset    (reset),
    .async_in (vs_udr),
    .rise     (udr_rise)
  );

  nios2_sync_edge #(.STAGES(SYNC_STAGES)) u_uir_sync (
    .clk      (clk),
    .reset    (reset),
    .async_in (vs_uir),
    .rise     (uir_rise)
  );

  logic [IR_W-1:0]  mem_ir   [FIFO_DEPTH];
  logic [SR_W-1:0]  mem_data [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             full;
  logic             pop;
  logic             wr_en;
  logic             drop;
  logic [IR_W-1:0]  push_ir;

  assign full      = (level == LVL_W'(FIFO_DEPTH));
  assign cmd_valid = (level != '0);
  assign cmd_ir    = mem_ir[rd_ptr];
  // A pop needs the head to be valid before this edge, so an empty queue
  // never pops even while a push is landing.
  assign pop       = cmd_valid & cmd_ready;
  // A full queue accepts a push only when the head leaves on the same edge.
  assign wr_en     = udr_rise & (~full | pop);
  assign drop      = udr_rise & full & ~pop;
  // Coincident update-IR and update-DR: the command carries the new IR.
  assign push_ir   = uir_rise ? ir_in : ir_cur;

  // Storage needs no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_ir[wr_ptr]   <= push_ir;
      mem_data[wr_ptr] <= sr;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      level       <= '0;
      overflow    <= 1'b0;
      ir_cur      <= '0;
      ir_update   <= 1'b0;
      jdo         <= '0;
      take_action <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
        jdo    <= mem_data[rd_ptr];
      end
      if (wr_en && !pop) begin
        level <= level + LVL_W'(1);
      end else if (pop && !wr_en) begin
        level <= level - LVL_W'(1);
      end

      take_action <= pop ? (NA_W'(1) << mem_ir[rd_ptr]) : '0;

      ir_update <= uir_rise;
      if (uir_rise) begin
        ir_cur <= ir_in;
      end

      // A drop on the same edge as a clear wins, so no loss goes unseen.
      if (drop) begin
        overflow <= 1'b1;
      end else if (ovf_clr) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule
